// File: rtl/tri_128x16_wrbuf_ctl.sv
// tri_128x16_wrbuf_ctl: write-buffered controller for a 128x16 bit-write array.
// Clears the array after reset, then buffers writes and serves bypass-merged reads.
//
// Ports:
//   clk, rst_b                     clock, async active-low reset
//   wr_req_val/rdy/adr/bw/di       write request (val&rdy handshake, per-bit enable)
//   rd_req_val/adr                 read request, no backpressure
//   rd_rsp_val/do                  read response, one cycle after the request
//   ary_wr_act/bw/wr_adr/di        array write port
//   ary_rd_act/rd_adr, ary_do      array read port, data one cycle after ary_rd_act
//   init_done, wrbuf_cnt           status
module tri_128x16_wrbuf_ctl #(
    parameter int addressbus_width = 7,
    parameter int port_bitwidth    = 16,
    parameter int wrbuf_depth      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_b,
    input  logic                                 wr_req_val,
    output logic                                 wr_req_rdy,
    input  logic [0:addressbus_width-1]          wr_req_adr,
    input  logic [0:port_bitwidth-1]             wr_req_bw,
    input  logic [0:port_bitwidth-1]             wr_req_di,
    input  logic                                 rd_req_val,
    input  logic [0:addressbus_width-1]          rd_req_adr,
    output logic                                 rd_rsp_val,
    output logic [0:port_bitwidth-1]             rd_rsp_do,
    output logic                                 ary_wr_act,
    output logic [0:port_bitwidth-1]             ary_bw,
    output logic [0:addressbus_width-1]          ary_wr_adr,
    output logic [0:port_bitwidth-1]             ary_di,
    output logic                                 ary_rd_act,
    output logic [0:addressbus_width-1]          ary_rd_adr,
    input  logic [0:port_bitwidth-1]             ary_do,
    output logic                                 init_done,
    output logic [0:$clog2(wrbuf_depth+1)-1]     wrbuf_cnt
);

    localparam int AW = addressbus_width;
    localparam int DW = port_bitwidth;
    localparam int CW = $clog2(wrbuf_depth + 1);
    localparam logic [0:CW-1] DEPTH_C = CW'(wrbuf_depth);
    localparam logic [0:AW-1] LAST_ADR = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic [0:AW-1] adr;
        logic [0:DW-1] bw;
        logic [0:DW-1] di;
    } ent_t;

    state_t         state_q, state_d;
    logic [0:AW-1]  icnt_q, icnt_d;
    // Age-ordered buffer: entry 0 is always the oldest (the head).
    ent_t           ent_q [wrbuf_depth];
    ent_t           ent_d [wrbuf_depth];
    logic [0:CW-1]  cnt_q, cnt_d;
    logic           rsp_val_q, rsp_val_d;
    logic [0:DW-1]  m_q, m_d;
    logic [0:DW-1]  d_q, d_d;

    logic           enq;
    logic           drain;
    logic [0:CW-1]  pos;
    logic [0:DW-1]  m;
    logic [0:DW-1]  d;

    always_comb begin
        state_d    = state_q;
        icnt_d     = icnt_q;
        ent_d      = ent_q;
        cnt_d      = cnt_q;
        wr_req_rdy = 1'b0;
        init_done  = 1'b0;
        ary_wr_act = 1'b0;
        ary_bw     = '0;
        ary_wr_adr = '0;
        ary_di     = '0;
        ary_rd_act = 1'b0;
        ary_rd_adr = '0;
        enq        = 1'b0;
        drain      = 1'b0;
        pos        = '0;
        m          = '0;
        d          = '0;

        unique case (state_q)
            INIT: begin
                ary_wr_act = 1'b1;
                ary_bw     = '1;
                ary_wr_adr = icnt_q;
                icnt_d     = icnt_q + AW'(1);
                if (icnt_q == LAST_ADR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                init_done  = 1'b1;
                wr_req_rdy = (cnt_q < DEPTH_C);
                drain      = (cnt_q != '0);
                // Zero-mask writes are handshaken but never stored.
                enq        = wr_req_val && wr_req_rdy && (wr_req_bw != '0);

                if (drain) begin
                    ary_wr_act = 1'b1;
                    ary_wr_adr = ent_q[0].adr;
                    ary_bw     = ent_q[0].bw;
                    ary_di     = ent_q[0].di;
                end

                ary_rd_act = rd_req_val;
                if (rd_req_val) begin
                    ary_rd_adr = rd_req_adr;
                end

                // Merge over entries present at cycle start, oldest first,
                // so younger writes win; includes the entry draining now
                // because the array read returns pre-drain contents.
                for (int i = 0; i < wrbuf_depth; i++) begin
                    if ((CW'(i) < cnt_q) && (ent_q[i].adr == rd_req_adr)) begin
                        d = (d & ~ent_q[i].bw) | (ent_q[i].di & ent_q[i].bw);
                        m = m | ent_q[i].bw;
                    end
                end

                if (drain) begin
                    for (int i = 0; i < wrbuf_depth - 1; i++) begin
                        ent_d[i] = ent_q[i+1];
                    end
                    ent_d[wrbuf_depth-1] = '0;
                end

                pos = drain ? (cnt_q - CW'(1)) : cnt_q;
                if (enq) begin
                    for (int i = 0; i < wrbuf_depth; i++) begin
                        if (CW'(i) == pos) begin
                            ent_d[i] = '{adr: wr_req_adr, bw: wr_req_bw, di: wr_req_di};
                        end
                    end
                end

                if (enq && !drain) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (drain && !enq) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        rsp_val_d = ary_rd_act;
        m_d       = ary_rd_act ? m : '0;
        d_d       = ary_rd_act ? d : '0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= INIT;
            icnt_q    <= '0;
            cnt_q     <= '0;
            rsp_val_q <= 1'b0;
            m_q       <= '0;
            d_q       <= '0;
            for (int i = 0; i < wrbuf_depth; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            icnt_q    <= icnt_d;
            cnt_q     <= cnt_d;
            rsp_val_q <= rsp_val_d;
            m_q       <= m_d;
            d_q       <= d_d;
            for (int i = 0; i < wrbuf_depth; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign rd_rsp_val = rsp_val_q;
    assign rd_rsp_do  = rsp_val_q ? ((ary_do & ~m_q) | (d_q & m_q)) : '0;
    assign wrbuf_cnt  = cnt_q;

endmodule

// File: tb/tb_tri_128x16_wrbuf_ctl.sv
// Bench for tri_128x16_wrbuf_ctl: emulated array, logical-memory reference
// model, randomized traffic plus a few hand-computed expectations.
module tb_tri_128x16_wrbuf_ctl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        wr_req_val;
    logic        wr_req_rdy;
    logic [0:6]  wr_req_adr;
    logic [0:15] wr_req_bw;
    logic [0:15] wr_req_di;
    logic        rd_req_val;
    logic [0:6]  rd_req_adr;
    logic        rd_rsp_val;
    logic [0:15] rd_rsp_do;
    logic        ary_wr_act;
    logic [0:15] ary_bw;
    logic [0:6]  ary_wr_adr;
    logic [0:15] ary_di;
    logic        ary_rd_act;
    logic [0:6]  ary_rd_adr;
    logic [0:15] ary_do;
    logic        init_done;
    logic [0:2]  wrbuf_cnt;

    always #5 clk = ~clk;

    tri_128x16_wrbuf_ctl dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .wr_req_val (wr_req_val),
        .wr_req_rdy (wr_req_rdy),
        .wr_req_adr (wr_req_adr),
        .wr_req_bw  (wr_req_bw),
        .wr_req_di  (wr_req_di),
        .rd_req_val (rd_req_val),
        .rd_req_adr (rd_req_adr),
        .rd_rsp_val (rd_rsp_val),
        .rd_rsp_do  (rd_rsp_do),
        .ary_wr_act (ary_wr_act),
        .ary_bw     (ary_bw),
        .ary_wr_adr (ary_wr_adr),
        .ary_di     (ary_di),
        .ary_rd_act (ary_rd_act),
        .ary_rd_adr (ary_rd_adr),
        .ary_do     (ary_do),
        .init_done  (init_done),
        .wrbuf_cnt  (wrbuf_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Emulated array
    logic [15:0] mem [128];
    logic [15:0] ado_q;
    logic        ado_garbage;

    // Reference model: what the memory logically holds, plus pending writes.
    typedef struct {
        logic [6:0]  a;
        logic [15:0] bw;
        logic [15:0] di;
    } went_t;
    went_t       q[$];
    logic [15:0] lmem [128];
    int          icnt;
    logic        pend;
    logic [15:0] pdata;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    task automatic drive(logic wv, logic [6:0] wa, logic [15:0] wb,
                         logic [15:0] wd, logic rv, logic [6:0] ra);
        wr_req_val = wv;
        wr_req_adr = wa;
        wr_req_bw  = wb;
        wr_req_di  = wd;
        rd_req_val = rv;
        rd_req_adr = ra;
    endtask

    task automatic drive_rand();
        int          sel;
        logic [15:0] b;
        logic [6:0]  wa;
        logic [6:0]  ra;
        sel = int'($urandom_range(0, 4));
        b = (sel == 0) ? 16'h0 : (sel == 1) ? 16'hFFFF : 16'($urandom);
        wa = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
        ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
        drive(1'($urandom_range(0, 1)), wa, b, 16'($urandom),
              ($urandom_range(0, 3) != 0), ra);
    endtask

    // Called at a falling edge with inputs already set; returns at the next one.
    task automatic tick();
        logic        in_init;
        logic        erdy;
        logic        acc;
        logic        nrv;
        logic [15:0] nrd;
        went_t       h;
        logic        c_wr;
        logic        c_rd;
        logic [6:0]  c_wa;
        logic [6:0]  c_ra;
        logic [15:0] c_bw;
        logic [15:0] c_di;
        #1;
        in_init = (icnt < 128);
        erdy    = !in_init && (q.size() < 4);
        if (in_init) begin
            chk("wr_port", {ary_wr_act, ary_wr_adr, ary_bw, ary_di},
                {1'b1, 7'(icnt), 16'hFFFF, 16'h0});
        end else if (q.size() > 0) begin
            h = q[0];
            chk("wr_port", {ary_wr_act, ary_wr_adr, ary_bw, ary_di},
                {1'b1, h.a, h.bw, h.di});
        end else begin
            chk("wr_port", {ary_wr_act, ary_wr_adr, ary_bw, ary_di}, 64'h0);
        end
        chk("rd_port", {ary_rd_act, ary_rd_adr},
            {!in_init && rd_req_val, (!in_init && rd_req_val) ? rd_req_adr : 7'h0});
        chk("rsp", {rd_rsp_val, rd_rsp_do}, {pend, pend ? pdata : 16'h0});
        chk("status", {wr_req_rdy, init_done, wrbuf_cnt},
            {erdy, !in_init, 3'(q.size())});
        c_wr = ary_wr_act;
        c_rd = ary_rd_act;
        c_wa = ary_wr_adr;
        c_ra = ary_rd_adr;
        c_bw = ary_bw;
        c_di = ary_di;

        @(posedge clk);
        if (c_rd) ado_q = mem[c_ra];
        if (c_wr) mem[c_wa] = (mem[c_wa] & ~c_bw) | (c_di & c_bw);
        ary_do = ado_garbage ? 16'($urandom) : ado_q;

        if (in_init) begin
            icnt++;
            pend = 1'b0;
        end else begin
            nrv = rd_req_val;
            nrd = lmem[rd_req_adr];
            acc = wr_req_val && erdy;
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                lmem[wr_req_adr] = (lmem[wr_req_adr] & ~wr_req_bw) |
                                   (wr_req_di & wr_req_bw);
                if (wr_req_bw != 16'h0) begin
                    h.a  = wr_req_adr;
                    h.bw = wr_req_bw;
                    h.di = wr_req_di;
                    q.push_back(h);
                end
            end
            pend  = nrv;
            pdata = nrd;
        end
        @(negedge clk);
    endtask

    // Asserted between edges so the clear must be asynchronous.
    task automatic do_reset();
        drive(1'b0, 7'h0, 16'h0, 16'h0, 1'b0, 7'h0);
        rst_b = 1'b0;
        #1;
        chk("rst_rsp_val", rd_rsp_val, 0);
        chk("rst_rsp_do", rd_rsp_do, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_cnt", wrbuf_cnt, 0);
        chk("rst_rdy", wr_req_rdy, 0);
        icnt = 0;
        q.delete();
        pend  = 1'b0;
        pdata = 16'h0;
        for (int i = 0; i < 128; i++) lmem[i] = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        chk("rel_wr_port", {ary_wr_act, ary_wr_adr, ary_di}, {1'b1, 7'h0, 16'h0});
        chk("rel_rsp_val", rd_rsp_val, 0);
    endtask

    task automatic run_init();
        for (int i = 0; i < 127; i++) begin
            drive_rand();
            tick();
        end
        chk("init_last_adr", ary_wr_adr, 127);
        chk("init_done_128", init_done, 0);
        drive_rand();
        tick();
        chk("init_done_129", init_done, 1);
        chk("run_wr_idle", ary_wr_act, 0);
    endtask

    initial begin
        rst_b       = 1'b0;
        ado_garbage = 1'b0;
        ado_q       = 16'h0;
        ary_do      = 16'h0;
        icnt        = 0;
        pend        = 1'b0;
        pdata       = 16'h0;
        drive(1'b0, 7'h0, 16'h0, 16'h0, 1'b0, 7'h0);
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        @(negedge clk);
        do_reset();
        run_init();

        drive(1'b0, 7'h0, 16'h0, 16'h0, 1'b1, 7'h05);
        tick();
        chk("rd05_val", rd_rsp_val, 1);
        chk("rd05_do", rd_rsp_do, 16'h0000);

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 7'(8 + i), 16'hFFFF, 16'($urandom), 1'b0, 7'h0);
            tick();
            chk("five_rdy", wr_req_rdy, 1);
            chk("five_cnt", wrbuf_cnt, 1);
        end

        drive(1'b1, 7'h10, 16'hFFFF, 16'hA5A5, 1'b0, 7'h0);
        tick();
        drive(1'b0, 7'h0, 16'h0, 16'h0, 1'b1, 7'h10);
        ado_garbage = 1'b1;
        tick();
        chk("bypass_full", rd_rsp_do, 16'hA5A5);
        ado_garbage = 1'b0;

        drive(1'b1, 7'h20, 16'hFFFF, 16'h5555, 1'b0, 7'h0);
        tick();
        drive(1'b1, 7'h20, 16'hFF00, 16'h1234, 1'b0, 7'h0);
        tick();
        drive(1'b1, 7'h20, 16'h00F0, 16'hABCD, 1'b0, 7'h0);
        tick();
        drive(1'b0, 7'h0, 16'h0, 16'h0, 1'b1, 7'h20);
        tick();
        chk("merge_20", rd_rsp_do, 16'h12C5);

        drive(1'b1, 7'h30, 16'h0000, 16'hFFFF, 1'b0, 7'h0);
        tick();
        chk("bw0_cnt", wrbuf_cnt, 0);
        chk("bw0_no_wr", ary_wr_act, 0);
        drive(1'b0, 7'h0, 16'h0, 16'h0, 1'b1, 7'h30);
        tick();
        chk("bw0_rd", rd_rsp_do, 16'h0000);

        for (int i = 0; i < 300; i++) begin
            drive_rand();
            tick();
        end

        drive(1'b1, 7'h40, 16'hFFFF, 16'h1111, 1'b1, 7'h40);
        tick();
        chk("pre_rst_cnt", wrbuf_cnt, 1);
        chk("pre_rst_rsp", rd_rsp_val, 1);
        do_reset();
        run_init();

        for (int i = 0; i < 300; i++) begin
            drive_rand();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
